ext_mem_responder: RTL and testbench

Memory-side responder for the 128-bit `mem_req`/`mem_resp` interface driven by the instruction and data caches. It accepts single-beat masked writes and burst read requests. Each read returns a 4-beat (512-bit) cache line after a programmable latency. The block is the synthesizable/simulation backing store that sits below both caches (through the arbiter) in the top-level testbench and in FPGA builds. It also exposes request counters for performance checks.

---
 rtl/ext_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_ext_mem_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_responder.sv
// Backing-store responder for the 128-bit mem_req/mem_resp interface.
// Accepts single-beat masked writes and returns 4-beat wrapped read bursts after READ_LATENCY cycles.
module ext_mem_responder #(
    parameter int ADDR_BITS    = 28,
    parameter int DATA_BITS    = 128,
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_req_valid,
    output logic                   mem_req_ready,
    input  logic [ADDR_BITS-1:0]   mem_req_addr,
    input  logic                   mem_req_rw,
    input  logic                   mem_req_data_valid,
    output logic                   mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                   mem_resp_valid,
    output logic [DATA_BITS-1:0]   mem_resp_data,
    output logic [31:0]            rd_count,
    output logic [31:0]            wr_count
);

    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam int CNT_BITS  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        RWAIT,
        BURST
    } state_t;

    state_t state_q, state_d;

    logic [DATA_BITS-1:0]  mem [DEPTH];

    logic [DEPTH_LOG2-1:0] base_q;
    logic [DEPTH_LOG2-1:0] waddr_q;
    logic [CNT_BITS-1:0]   lat_q;
    logic [1:0]            beat_q;
    logic [31:0]           rd_count_q;
    logic [31:0]           wr_count_q;
    logic                  resp_valid_q;
    logic [DATA_BITS-1:0]  resp_data_q;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] we_addr;
    logic                  rd_accept;
    logic                  wr_defer;
    logic                  beat_load;
    logic [1:0]            beat_sel;
    logic [DEPTH_LOG2-1:0] rd_base;
    logic [DEPTH_LOG2-1:0] rd_addr;

    logic                  unused_addr_hi;
    assign unused_addr_hi = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

    always_comb begin
        state_d            = state_q;
        mem_req_ready      = 1'b0;
        mem_req_data_ready = 1'b0;
        mem_we             = 1'b0;
        we_addr            = waddr_q;
        rd_accept          = 1'b0;
        wr_defer           = 1'b0;
        beat_load          = 1'b0;
        beat_sel           = 2'd0;

        case (state_q)
            IDLE: begin
                mem_req_ready      = !reset;
                mem_req_data_ready = !reset && mem_req_valid && mem_req_rw;
                if (mem_req_valid && mem_req_ready) begin
                    if (mem_req_rw) begin
                        if (mem_req_data_valid) begin
                            mem_we  = 1'b1;
                            we_addr = mem_req_addr[DEPTH_LOG2-1:0];
                        end else begin
                            wr_defer = 1'b1;
                            state_d  = WDATA;
                        end
                    end else begin
                        rd_accept = 1'b1;
                        if (READ_LATENCY == 1) begin
                            // No wait cycles: the first beat is registered on the accept edge itself.
                            beat_load = 1'b1;
                            state_d   = BURST;
                        end else begin
                            state_d   = RWAIT;
                        end
                    end
                end
            end
            WDATA: begin
                mem_req_data_ready = !reset;
                if (mem_req_data_valid && !reset) begin
                    mem_we  = 1'b1;
                    state_d = IDLE;
                end
            end
            RWAIT: begin
                // Beat 0 is loaded on the edge where the counter reaches zero.
                if (lat_q == CNT_BITS'(1)) begin
                    beat_load = 1'b1;
                    state_d   = BURST;
                end
            end
            BURST: begin
                if (beat_q == 2'd3) begin
                    state_d = IDLE;
                end else begin
                    beat_load = 1'b1;
                    beat_sel  = beat_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Critical beat first, wrapping inside the aligned 4-beat line.
    assign rd_base = rd_accept ? mem_req_addr[DEPTH_LOG2-1:0] : base_q;
    assign rd_addr = {rd_base[DEPTH_LOG2-1:2], rd_base[1:0] + beat_sel};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            waddr_q      <= '0;
            lat_q        <= '0;
            beat_q       <= '0;
            rd_count_q   <= '0;
            wr_count_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (rd_accept) begin
                base_q     <= mem_req_addr[DEPTH_LOG2-1:0];
                lat_q      <= CNT_BITS'(READ_LATENCY - 1);
                beat_q     <= 2'd0;
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (wr_defer) begin
                waddr_q <= mem_req_addr[DEPTH_LOG2-1:0];
            end
            if (state_q == RWAIT) begin
                lat_q <= lat_q - CNT_BITS'(1);
            end
            if (state_q == BURST) begin
                beat_q <= beat_q + 2'd1;
            end
            if (mem_we) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            resp_valid_q <= beat_load;
            resp_data_q  <= beat_load ? mem[rd_addr] : '0;
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < MASK_BITS; i++) begin
                if (mem_req_data_mask[i]) begin
                    mem[we_addr][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
                end
            end
        end
    end

    assign mem_resp_valid = resp_valid_q;
    assign mem_resp_data  = resp_data_q;
    assign rd_count       = rd_count_q;
    assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Randomized bench for ext_mem_responder against a cycle-level behavioural model of writes, bursts and counters.
module tb_ext_mem_responder;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [27:0]  mem_req_addr;
    logic         mem_req_rw;
    logic         mem_req_data_valid;
    logic         mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;

    ext_mem_responder #(
        .ADDR_BITS   (28),
        .DATA_BITS   (128),
        .DEPTH_LOG2  (12),
        .READ_LATENCY(L)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_req_rw        (mem_req_rw),
        .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits (mem_req_data_bits),
        .mem_req_data_mask (mem_req_data_mask),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data),
        .rd_count          (rd_count),
        .wr_count          (wr_count)
    );

    always #5 clk = ~clk;

    int unsigned  n_cmp = 0;
    int unsigned  n_err = 0;
    logic [127:0] ref_mem [4096];
    bit           ref_wr  [4096];
    logic [31:0]  rd_exp = 0;
    logic [31:0]  wr_exp = 0;
    int unsigned  lines [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Storage index of beat k of a burst that starts at addr.
    function automatic int unsigned beat_index(input logic [27:0] addr, input int unsigned k);
        int unsigned a;
        a = int'(addr) % 4096;
        return (a / 4) * 4 + (a + k) % 4;
    endfunction

    task automatic model_write(input logic [27:0] addr, input logic [127:0] data, input logic [15:0] mask);
        int unsigned a;
        a = int'(addr) % 4096;
        for (int b = 0; b < 16; b++)
            if (mask[b]) ref_mem[a][8*b +: 8] = data[8*b +: 8];
        if (mask == 16'hFFFF) ref_wr[a] = 1'b1;
        wr_exp = wr_exp + 1;
    endtask

    task automatic drive_idle();
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_addr       = 28'($urandom);
        mem_req_data_bits  = rand128();
        mem_req_data_mask  = 16'($urandom);
    endtask

    // All transaction tasks start and end just after a falling edge.
    task automatic write_same(input logic [27:0] addr, input logic [127:0] data, input logic [15:0] mask);
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_data_valid = 1'b1;
        mem_req_addr       = addr;
        mem_req_data_bits  = data;
        mem_req_data_mask  = mask;
        #1;
        check("wr_req_ready", 128'(mem_req_ready), 128'(1));
        check("wr_data_ready", 128'(mem_req_data_ready), 128'(1));
        @(negedge clk);
        model_write(addr, data, mask);
        drive_idle();
        #1;
        check("wr_count", 128'(wr_count), 128'(wr_exp));
    endtask

    task automatic write_split(input logic [27:0] addr, input logic [127:0] data,
                               input logic [15:0] mask, input int unsigned gap);
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_data_valid = 1'b0;
        mem_req_addr       = addr;
        #1;
        check("split_req_ready", 128'(mem_req_ready), 128'(1));
        @(negedge clk);
        for (int unsigned g = 0; g < gap; g++) begin
            mem_req_valid = 1'($urandom);
            mem_req_addr  = 28'($urandom);
            #1;
            check("wdata_req_ready", 128'(mem_req_ready), 128'(0));
            check("wdata_data_ready", 128'(mem_req_data_ready), 128'(1));
            check("wdata_wr_count", 128'(wr_count), 128'(wr_exp));
            @(negedge clk);
        end
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = data;
        mem_req_data_mask  = mask;
        #1;
        check("wdata_fire_ready", 128'(mem_req_data_ready), 128'(1));
        @(negedge clk);
        model_write(addr, data, mask);
        drive_idle();
        #1;
        check("split_wr_count", 128'(wr_count), 128'(wr_exp));
        check("split_back_idle", 128'(mem_req_ready), 128'(1));
    endtask

    task automatic do_read(input logic [27:0] addr);
        int unsigned idx;
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_addr       = addr;
        #1;
        check("rd_req_ready", 128'(mem_req_ready), 128'(1));
        @(negedge clk);
        rd_exp = rd_exp + 1;
        for (int unsigned c = 1; c <= L + 3; c++) begin
            // Requests offered while busy must be ignored.
            mem_req_valid      = 1'($urandom);
            mem_req_rw         = 1'($urandom);
            mem_req_data_valid = 1'($urandom);
            mem_req_addr       = 28'($urandom);
            #1;
            check("busy_req_ready", 128'(mem_req_ready), 128'(0));
            check("busy_data_ready", 128'(mem_req_data_ready), 128'(0));
            if (c >= L) begin
                idx = beat_index(addr, c - L);
                check("beat_valid", 128'(mem_resp_valid), 128'(1));
                if (ref_wr[idx]) check("beat_data", mem_resp_data, ref_mem[idx]);
            end else begin
                check("wait_valid", 128'(mem_resp_valid), 128'(0));
                check("wait_data", mem_resp_data, 128'(0));
            end
            @(negedge clk);
        end
        drive_idle();
        #1;
        check("rd_ready_again", 128'(mem_req_ready), 128'(1));
        check("rd_end_valid", 128'(mem_resp_valid), 128'(0));
        check("rd_end_data", mem_resp_data, 128'(0));
        check("rd_count", 128'(rd_count), 128'(rd_exp));
        check("rd_wr_count", 128'(wr_count), 128'(wr_exp));
    endtask

    task automatic read_then_reset(input logic [27:0] addr);
        int unsigned idx;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = addr;
        @(negedge clk);
        drive_idle();
        repeat (L) @(negedge clk);
        #1;
        idx = beat_index(addr, 1);
        check("mid_beat1_valid", 128'(mem_resp_valid), 128'(1));
        if (ref_wr[idx]) check("mid_beat1_data", mem_resp_data, ref_mem[idx]);
        reset = 1'b1;
        @(negedge clk);
        #1;
        rd_exp = 0;
        wr_exp = 0;
        check("mid_rst_valid", 128'(mem_resp_valid), 128'(0));
        check("mid_rst_data", mem_resp_data, 128'(0));
        check("mid_rst_ready", 128'(mem_req_ready), 128'(0));
        check("mid_rst_rd_count", 128'(rd_count), 128'(rd_exp));
        reset = 1'b0;
        #1;
        check("mid_rel_ready", 128'(mem_req_ready), 128'(1));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("mid_no_beats", 128'(mem_resp_valid), 128'(0));
        end
    endtask

    initial begin
        logic [27:0] a;
        logic [9:0]  ln;
        int unsigned sel;

        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready_low", 128'(mem_req_ready), 128'(0));
        check("rst_data_ready", 128'(mem_req_data_ready), 128'(0));
        check("rst_valid", 128'(mem_resp_valid), 128'(0));
        check("rst_data", mem_resp_data, 128'(0));
        reset = 1'b0;
        #1;
        check("post_rst_ready", 128'(mem_req_ready), 128'(1));
        check("post_rst_rd_count", 128'(rd_count), 128'(0));
        check("post_rst_wr_count", 128'(wr_count), 128'(0));

        for (int i = 0; i < 4; i++)
            write_same(28'h40 + 28'(i), 128'hA0 + 128'(i), 16'hFFFF);
        do_read(28'h40);
        do_read(28'h41);

        for (int i = 1; i < 4; i++)
            write_same(28'h10 + 28'(i), rand128(), 16'hFFFF);
        write_same(28'h10, '1, 16'hFFFF);
        write_same(28'h10, 128'h11223344, 16'h000F);
        do_read(28'h10);

        for (int i = 1; i < 4; i++)
            write_same(28'h20 + 28'(i), rand128(), 16'hFFFF);
        write_split(28'h20, rand128(), 16'hFFFF, 2);
        do_read(28'h20);

        // A data beat without a write request must not be consumed.
        mem_req_data_valid = 1'b1;
        #1;
        check("orphan_data_ready", 128'(mem_req_data_ready), 128'(0));
        @(negedge clk);
        drive_idle();
        #1;
        check("orphan_wr_count", 128'(wr_count), 128'(wr_exp));

        for (int n = 0; n < 8; n++) begin
            ln = 10'($urandom);
            lines.push_back(int'(ln));
            for (int k = 0; k < 4; k++) begin
                a = 28'($urandom);
                a[11:0] = {ln, 2'(k)};
                write_same(a, rand128(), 16'hFFFF);
            end
        end
        for (int op = 0; op < 120; op++) begin
            ln = 10'(lines[$urandom_range(0, lines.size() - 1)]);
            a = 28'($urandom);
            a[11:0] = {ln, 2'($urandom)};
            sel = $urandom_range(0, 9);
            if (sel < 4)      write_same(a, rand128(), 16'($urandom));
            else if (sel < 6) write_split(a, rand128(), 16'($urandom), $urandom_range(0, 3));
            else              do_read(a);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        read_then_reset(28'h40);
        do_read(28'h43);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
